// File: rtl/data_collector_4lane.sv
// Four-lane sample collector: change-detect strobes, per-lane holding registers,
// round-robin merge into a first-word-fall-through FIFO, and a per-lane ramp checker.
module data_collector_4lane #(
   parameter int DATA_WIDTH = 32,
   parameter int START      = -512,
   parameter int END        = 512,
   parameter int STRIDE     = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk_200MHz,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_channel1_data1,
   input  logic [DATA_WIDTH-1:0] in_channel1_data2,
   input  logic [DATA_WIDTH-1:0] in_channel2_data1,
   input  logic [DATA_WIDTH-1:0] in_channel2_data2,
   input  logic                  in_channel1_data1_valid,
   input  logic                  in_channel1_data2_valid,
   input  logic                  in_channel2_data1_valid,
   input  logic                  in_channel2_data2_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_lane,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overflow,
   output logic [15:0]           err_count
);

   localparam int NUM_LANES = 4;
   localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [DATA_WIDTH-1:0] START_W  = DATA_WIDTH'(START);
   localparam logic [DATA_WIDTH-1:0] END_W    = DATA_WIDTH'(END);
   localparam logic [DATA_WIDTH-1:0] STRIDE_W = DATA_WIDTH'(STRIDE);
   localparam logic [AW:0]           DEPTH_W  = FIFO_DEPTH[AW:0];

   logic [NUM_LANES-1:0]  in_valid;
   logic [DATA_WIDTH-1:0] in_data [NUM_LANES];

   assign in_valid   = {in_channel2_data2_valid, in_channel2_data1_valid,
                        in_channel1_data2_valid, in_channel1_data1_valid};
   assign in_data[0] = in_channel1_data1;
   assign in_data[1] = in_channel1_data2;
   assign in_data[2] = in_channel2_data1;
   assign in_data[3] = in_channel2_data2;

   // ---------------- change-detect strobe stage ----------------
   logic [NUM_LANES-1:0]  prev_valid;
   logic [NUM_LANES-1:0]  new_sample;
   logic [NUM_LANES-1:0]  strobe;
   logic [DATA_WIDTH-1:0] last_word [NUM_LANES];
   logic [DATA_WIDTH-1:0] sample    [NUM_LANES];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      new_sample = '0;
      for (int l = 0; l < NUM_LANES; l++)
         new_sample[l] = in_valid[l] && (!prev_valid[l] || (in_data[l] != last_word[l]));
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_200MHz or negedge rst_n) begin
      if (!rst_n) begin
         prev_valid <= '0;
         strobe     <= '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            last_word[l] <= '0;
            sample[l]    <= '0;
         end
      end else begin
         prev_valid <= in_valid;
         strobe     <= new_sample;
         for (int l = 0; l < NUM_LANES; l++) begin
            if (new_sample[l]) begin
               last_word[l] <= in_data[l];
               sample[l]    <= in_data[l];
            end
         end
      end
   end

   // ---------------- holding registers ----------------
   logic [NUM_LANES-1:0]  pending;
   logic [NUM_LANES-1:0]  grant;
   logic [DATA_WIDTH-1:0] hold_word [NUM_LANES];

   always_ff @(posedge clk_200MHz or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         overflow <= 1'b0;
         for (int l = 0; l < NUM_LANES; l++) hold_word[l] <= '0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            // A drain in the same cycle frees the slot, so the new word is kept.
            if (strobe[l] && (!pending[l] || grant[l])) begin
               hold_word[l] <= sample[l];
               pending[l]   <= 1'b1;
            end else if (grant[l]) begin
               pending[l]   <= 1'b0;
            end
         end
         if (|(strobe & pending & ~grant)) overflow <= 1'b1;
      end
   end

   // ---------------- round-robin arbiter ----------------
   logic [1:0] rr_ptr;
   logic [1:0] cand;
   logic [1:0] grant_lane;
   logic       grant_valid;
   logic       fifo_full;
   logic       fifo_rd;

   always_comb begin
      grant       = '0;
      grant_lane  = rr_ptr;
      grant_valid = 1'b0;
      cand        = rr_ptr;
      if (!fifo_full || fifo_rd) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            cand = rr_ptr + 2'(i);
            if (!grant_valid && pending[cand]) begin
               grant_valid = 1'b1;
               grant_lane  = cand;
            end
         end
      end
      if (grant_valid) grant[grant_lane] = 1'b1;
   end

   always_ff @(posedge clk_200MHz or negedge rst_n) begin
      if (!rst_n)           rr_ptr <= '0;
      else if (grant_valid) rr_ptr <= grant_lane + 2'd1;
   end

   // ---------------- first-word-fall-through FIFO ----------------
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [1:0]            fifo_lane [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           fifo_count;

   assign fifo_full = (fifo_count == DEPTH_W);
   assign out_valid = (fifo_count != '0);
   assign fifo_rd   = out_valid && out_ready;
   assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
   assign out_lane  = out_valid ? fifo_lane[rd_ptr] : 2'd0;

   // NOTE: storage array has no reset; only pointers and count define what is valid.
   always_ff @(posedge clk_200MHz) begin
      if (grant_valid) begin
         fifo_data[wr_ptr] <= hold_word[grant_lane];
         fifo_lane[wr_ptr] <= grant_lane;
      end
   end

   always_ff @(posedge clk_200MHz or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (grant_valid) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_rd)     rd_ptr <= rd_ptr + 1'b1;
         if (grant_valid && !fifo_rd)      fifo_count <= fifo_count + 1'b1;
         else if (!grant_valid && fifo_rd) fifo_count <= fifo_count - 1'b1;
      end
   end

   // ---------------- ramp checker ----------------
   logic [DATA_WIDTH-1:0] expected      [NUM_LANES];
   logic [DATA_WIDTH-1:0] next_expected [NUM_LANES];
   logic [2:0]            mismatches;
   logic [16:0]           err_sum;

   always_comb begin
      mismatches = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         next_expected[l] = (sample[l] == END_W) ? START_W : sample[l] + STRIDE_W;
         if (strobe[l] && (sample[l] != expected[l])) mismatches = mismatches + 3'd1;
      end
      err_sum = {1'b0, err_count} + {14'd0, mismatches};
   end

   always_ff @(posedge clk_200MHz or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
         for (int l = 0; l < NUM_LANES; l++) expected[l] <= START_W;
      end else begin
         // Match or mismatch, the checker resyncs to the word just seen.
         for (int l = 0; l < NUM_LANES; l++)
            if (strobe[l]) expected[l] <= next_expected[l];
         err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end

endmodule
